// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, packs dibits into DATA_WIDTH-bit words,
// checks the FCS with a 2-bit-per-cycle CRC-32 and reports per-frame status on done.
module rmii_rx_framer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MIN_BYTES   = 64,
  parameter int MAX_BYTES   = 1522,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  crsdv,
  input  logic [1:0]            rxd,
  input  logic                  rxerr,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  outclk,
  output logic                  done,
  output logic                  crc_ok,
  output logic                  len_err,
  output logic                  align_err,
  output logic                  rx_err,
  output logic [15:0]           byte_count
);

  localparam logic [2:0] S_DRAIN    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_PREAMBLE = 3'd3;
  localparam logic [2:0] S_RECV     = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam int          KW      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH / 2) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DATA_WIDTH / 2 - 1);
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_L   = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_L   = 16'(MAX_BYTES);

  logic [2:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   crsdv_s;
  logic                   prev;
  logic                   dv;
  logic [DATA_WIDTH-1:0]  word;
  logic [DATA_WIDTH-1:0]  word_next;
  logic [KW-1:0]          k;
  logic [1:0]             dcnt;
  logic [15:0]            bcnt;
  logic [31:0]            crc;
  logic [31:0]            crc_next;
  logic                   err_seen;

  assign crsdv_s = sync[SYNC_STAGES-1];
  // Holds valid across the CRS-low half of the end-of-frame toggle pattern.
  assign dv      = crsdv | (crsdv != prev);

  always_comb begin
    word_next = word;
    for (int unsigned i = 0; i < DATA_WIDTH / 2; i++) begin
      if (k == KW'(i)) word_next[2*i +: 2] = rxd;
    end
    crc_next = crc;
    for (int unsigned b = 0; b < 2; b++) begin
      crc_next = {1'b0, crc_next[31:1]} ^ ((crc_next[0] ^ rxd[b]) ? POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_DRAIN;
      // Synchroniser comes up "carrier present" so DRAIN waits for a real idle gap.
      sync       <= '1;
      prev       <= 1'b0;
      out        <= '0;
      outclk     <= 1'b0;
      done       <= 1'b0;
      crc_ok     <= 1'b0;
      len_err    <= 1'b0;
      align_err  <= 1'b0;
      rx_err     <= 1'b0;
      byte_count <= '0;
      word       <= '0;
      k          <= '0;
      dcnt       <= '0;
      bcnt       <= '0;
      crc        <= '1;
      err_seen   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], crsdv};
      prev   <= crsdv;
      outclk <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_DRAIN: if (!crsdv_s) state <= S_IDLE;
        S_IDLE: begin
          if (crsdv_s) begin
            state    <= S_WAIT;
            word     <= '0;
            k        <= '0;
            dcnt     <= '0;
            bcnt     <= '0;
            crc      <= '1;
            err_seen <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!crsdv)            state <= S_IDLE;
          else if (rxd == 2'b01) state <= S_PREAMBLE;
        end
        S_PREAMBLE: begin
          if (!crsdv)            state <= S_IDLE;
          else if (rxd == 2'b11) state <= S_RECV;
        end
        S_RECV: begin
          if (rxerr) err_seen <= 1'b1;
          if (dv) begin
            crc  <= crc_next;
            dcnt <= dcnt + 2'd1;
            if (dcnt == 2'd3 && bcnt != '1) bcnt <= bcnt + 16'd1;
            if (k == K_LAST) begin
              out    <= word_next;
              outclk <= 1'b1;
              word   <= '0;
              k      <= '0;
            end else begin
              word <= word_next;
              k    <= k + KW'(1);
            end
          end else begin
            state <= (k != '0) ? S_FLUSH : S_DONE;
          end
        end
        S_FLUSH: begin
          out    <= word;
          outclk <= 1'b1;
          word   <= '0;
          k      <= '0;
          state  <= S_DONE;
        end
        S_DONE: begin
          done       <= 1'b1;
          crc_ok     <= (crc == RESIDUE);
          len_err    <= (bcnt < MIN_L) || (bcnt > MAX_L) || (bcnt == '1);
          align_err  <= (dcnt != 2'd0);
          rx_err     <= err_seen;
          byte_count <= bcnt;
          state      <= S_IDLE;
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: 8-bit and 32-bit instances share the RMII pins.
module tb_rmii_rx_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic        rxerr = 1'b0;

  logic [7:0]  out8;
  logic        outclk8, done8, crc_ok8, len_err8, align_err8, rx_err8;
  logic [15:0] bc8;
  logic [31:0] out32;
  logic        outclk32, done32, crc_ok32, len_err32, align_err32, rx_err32;
  logic [15:0] bc32;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  frame [0:127];
  logic [7:0]  q8 [$];
  logic [31:0] q32 [$];
  int cyc = 0;
  int last_oc32 = 0;
  int done32_cyc = 0;
  int n_done8 = 0;
  int n_done32 = 0;
  logic s8_crc, s8_len, s8_align, s8_rxe, s32_crc;
  logic [15:0] s8_cnt;

  rmii_rx_framer #(.DATA_WIDTH(8), .MIN_BYTES(64), .MAX_BYTES(1522), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .crsdv(crsdv), .rxd(rxd), .rxerr(rxerr),
    .out(out8), .outclk(outclk8), .done(done8), .crc_ok(crc_ok8), .len_err(len_err8),
    .align_err(align_err8), .rx_err(rx_err8), .byte_count(bc8)
  );

  rmii_rx_framer #(.DATA_WIDTH(32), .MIN_BYTES(64), .MAX_BYTES(1522), .SYNC_STAGES(2)) dut32 (
    .clk(clk), .reset(reset), .crsdv(crsdv), .rxd(rxd), .rxerr(rxerr),
    .out(out32), .outclk(outclk32), .done(done32), .crc_ok(crc_ok32), .len_err(len_err32),
    .align_err(align_err32), .rx_err(rx_err32), .byte_count(bc32)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (outclk8) q8.push_back(out8);
    if (outclk32) begin
      q32.push_back(out32);
      last_oc32 <= cyc;
    end
    if (done8) begin
      n_done8  <= n_done8 + 1;
      s8_crc   <= crc_ok8;
      s8_len   <= len_err8;
      s8_align <= align_err8;
      s8_rxe   <= rx_err8;
      s8_cnt   <= bc8;
    end
    if (done32) begin
      n_done32   <= n_done32 + 1;
      s32_crc    <= crc_ok32;
      done32_cyc <= cyc;
    end
  end

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ frame[i][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                    c = c >> 1;
      end
    end
    return c;
  endfunction

  // ndata payload bytes (broadcast destination) followed by a correct FCS, LSB byte first.
  task automatic build(input int ndata, input int seed);
    logic [31:0] fcs;
    for (int i = 0; i < ndata; i++) frame[i] = (i < 6) ? 8'hFF : 8'((i * 37 + seed) & 8'hFF);
    fcs = ~crc_of(ndata);
    for (int b = 0; b < 4; b++) frame[ndata + b] = fcs[8*b +: 8];
  endtask

  // The framer keeps dv one cycle past CRS_DV's final fall, so the last dibit rides that cycle.
  task automatic send_frame(input int nbytes, input int extra, input bit tog, input int err_at,
                            input int ipg);
    int n;
    logic [7:0] b;
    n = nbytes * 4 + extra;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      crsdv = 1'b1;
      rxd   = (i == 31) ? 2'b11 : 2'b01;
      rxerr = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b     = (i / 4 < nbytes) ? frame[i / 4] : 8'h02;
      rxd   = b[2*(i % 4) +: 2];
      rxerr = (i == err_at);
      if (i == n - 1)                crsdv = 1'b0;
      else if (tog && i >= n - 8)    crsdv = ((i - (n - 8)) % 2 == 0);
      else                           crsdv = 1'b1;
    end
    for (int i = 0; i < ipg; i++) begin
      @(negedge clk);
      crsdv = 1'b0;
      rxd   = 2'b00;
      rxerr = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({out8, outclk8, done8, crc_ok8, len_err8, align_err8, rx_err8, bc8} !== '0) begin
      n_err++;
      $display("FAIL reset8 got out=%h oc=%b done=%b bc=%0d want all 0", out8, outclk8, done8, bc8);
    end
    n_chk++;
    if ({out32, outclk32, done32, crc_ok32, bc32} !== '0) begin
      n_err++;
      $display("FAIL reset32 got out=%h oc=%b done=%b want all 0", out32, outclk32, done32);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_bytes8(input string name, input int nb);
    n_chk++;
    if (q8.size() != nb) begin
      n_err++;
      $display("FAIL %s_count got %0d want %0d", name, q8.size(), nb);
    end
    for (int i = 0; i < nb && i < q8.size(); i++) begin
      n_chk++;
      if (q8[i] !== frame[i]) begin
        n_err++;
        $display("FAIL %s_byte%0d got %h want %h", name, i, q8[i], frame[i]);
      end
    end
  endtask

  task automatic test_valid64;
    int d0;
    q8.delete();
    build(60, 3);
    d0 = n_done8;
    send_frame(64, 0, 1'b0, -1, 12);
    check_bytes8("valid64", 64);
    n_chk++;
    if (n_done8 != d0 + 1) begin n_err++; $display("FAIL valid64_done got %0d want %0d", n_done8 - d0, 1); end
    n_chk++;
    if ({s8_crc, s8_len, s8_align, s8_rxe} !== 4'b1000) begin
      n_err++;
      $display("FAIL valid64_status got %b want 1000", {s8_crc, s8_len, s8_align, s8_rxe});
    end
    n_chk++;
    if (s8_cnt !== 16'd64) begin n_err++; $display("FAIL valid64_bytecount got %0d want 64", s8_cnt); end
  endtask

  task automatic test_bad_crc;
    q8.delete();
    build(60, 3);
    frame[20] = frame[20] ^ 8'h10;
    send_frame(64, 0, 1'b0, -1, 12);
    check_bytes8("badcrc", 64);
    n_chk++;
    if (s8_crc !== 1'b0) begin n_err++; $display("FAIL badcrc_crc_ok got %b want 0", s8_crc); end
    n_chk++;
    if ({s8_len, s8_align, s8_cnt} !== {2'b00, 16'd64}) begin
      n_err++;
      $display("FAIL badcrc_len got len=%b align=%b cnt=%0d want 0 0 64", s8_len, s8_align, s8_cnt);
    end
  endtask

  task automatic test_wide_flush;
    logic [31:0] exp;
    int d0;
    q32.delete();
    build(62, 11);
    d0 = n_done32;
    send_frame(66, 0, 1'b0, -1, 12);
    n_chk++;
    if (q32.size() != 17) begin n_err++; $display("FAIL wide_count got %0d want 17", q32.size()); end
    for (int i = 0; i < 17 && i < q32.size(); i++) begin
      exp = (i < 16) ? {frame[4*i+3], frame[4*i+2], frame[4*i+1], frame[4*i]}
                     : {16'h0000, frame[65], frame[64]};
      n_chk++;
      if (q32[i] !== exp) begin n_err++; $display("FAIL wide_word%0d got %h want %h", i, q32[i], exp); end
    end
    n_chk++;
    if (n_done32 != d0 + 1) begin n_err++; $display("FAIL wide_done got %0d want 1", n_done32 - d0); end
    n_chk++;
    if (done32_cyc - last_oc32 != 1) begin
      n_err++;
      $display("FAIL wide_done_gap got %0d want 1", done32_cyc - last_oc32);
    end
    n_chk++;
    if (s32_crc !== 1'b1) begin n_err++; $display("FAIL wide_crc_ok got %b want 1", s32_crc); end
  endtask

  task automatic test_short_odd_err;
    q8.delete();
    build(36, 5);
    send_frame(40, 1, 1'b0, 80, 12);
    n_chk++;
    if ({s8_len, s8_align, s8_rxe} !== 3'b111) begin
      n_err++;
      $display("FAIL short_flags got %b want 111", {s8_len, s8_align, s8_rxe});
    end
    n_chk++;
    if (s8_cnt !== 16'd40) begin n_err++; $display("FAIL short_bytecount got %0d want 40", s8_cnt); end
    n_chk++;
    if (q8.size() != 41) begin n_err++; $display("FAIL short_words got %0d want 41", q8.size()); end
    else begin
      n_chk++;
      if (q8[40] !== 8'h02) begin n_err++; $display("FAIL short_flush got %h want 02", q8[40]); end
    end
  endtask

  task automatic test_crs_toggle;
    q8.delete();
    build(60, 77);
    send_frame(64, 0, 1'b1, -1, 12);
    check_bytes8("toggle", 64);
    n_chk++;
    if ({s8_crc, s8_align} !== 2'b10) begin
      n_err++;
      $display("FAIL toggle_status got crc=%b align=%b want 1 0", s8_crc, s8_align);
    end
  endtask

  task automatic test_back_to_back;
    int d0;
    build(60, 9);
    d0 = n_done8;
    fork
      send_frame(64, 0, 1'b0, -1, 12);
      begin
        repeat (52) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++;
        if ({out8, outclk8, done8, crc_ok8, len_err8, align_err8, rx_err8, bc8} !== '0) begin
          n_err++;
          $display("FAIL midreset_out got out=%h oc=%b crc=%b bc=%0d want all 0", out8, outclk8, crc_ok8, bc8);
        end
      end
    join
    n_chk++;
    if (n_done8 != d0) begin n_err++; $display("FAIL midreset_nodone got %0d want 0", n_done8 - d0); end
    q8.delete();
    build(60, 123);
    send_frame(64, 0, 1'b0, -1, 12);
    check_bytes8("b2b", 64);
    n_chk++;
    if (n_done8 != d0 + 1) begin n_err++; $display("FAIL b2b_done got %0d want 1", n_done8 - d0); end
    n_chk++;
    if ({s8_crc, s8_cnt} !== {1'b1, 16'd64}) begin
      n_err++;
      $display("FAIL b2b_status got crc=%b cnt=%0d want 1 64", s8_crc, s8_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_valid64;
    test_bad_crc;
    test_wide_flush;
    test_short_odd_err;
    test_crs_toggle;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
